// File: rtl/sr_mul_iter_if.sv
// rtl/sr_mul_iter_if.sv - request/response bundle between the core and the iterative multiplier
interface sr_mul_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/sr_mul_iter.sv
// rtl/sr_mul_iter.sv - iterative shift-add multiplier returning the low WIDTH bits of a*b
module sr_mul_iter #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    sr_mul_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_mplier_shr;
    logic             w_last;
    logic             w_skip_run;

    assign w_mplier_shr = r_mplier >> 1;

    // Early exit only matters when no set multiplier bits remain after this step.
    assign w_last     = (r_count == CW'(WIDTH - 1)) || (EARLY_OUT && (w_mplier_shr == '0));
    assign w_skip_run = EARLY_OUT && (bus.b == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = w_skip_run ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mcand  <= bus.a;
                        r_mplier <= bus.b;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_count  <= r_count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_acc;
endmodule
